// File: rtl/rv_wb_pkg.sv
// Shared writeback definitions for the register-file write arbiter.
// Holds the data width, register address width, divider-result buffer depth,
// starvation limit and the buffered entry type {addr, data}.
package rv_wb_pkg;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// Strict-order buffer for divider results waiting for a register-file write slot.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   push, push_entry  : append an entry at the tail (ignored when full)
//   pop               : remove the head entry (ignored when empty)
//   head              : current head entry
//   count, full, empty: occupancy
//   entry_valid/addr  : per-slot occupancy and destination register
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry                      push_entry,
  input  logic                         pop,
  output wb_entry                      head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] entry_addr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  wb_entry          mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] vld;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  assign entry_valid = vld;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem[i].addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr      <= ptr_inc(wr_ptr);
        vld[wr_ptr] <= 1'b1;
      end
      // Push and pop never hit the same slot: a push needs !full, a pop needs !empty.
      if (pop_ok) begin
        rd_ptr      <= ptr_inc(rd_ptr);
        vld[rd_ptr] <= 1'b0;
      end
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; slot validity is tracked by vld.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter between the pipeline writeback and a
// buffered divider result stream. The pipeline wins whenever it writes a
// nonzero register; buffered divider results drain in order otherwise, and a
// stall request forces a bubble if the head result waits too long.
// Ports:
//   clk, reset                              : clock, async active-low reset
//   pipe_wb_valid/addr/data                 : pipeline writeback request
//   div_valid/addr/data, div_ready          : divider result handshake
//   write_enable, write_reg_addr,
//   reg_write_data                          : registered register-file write port
//   div_pending_mask                        : registers with an outstanding divider result
//   stall_req                               : asks upstream for a writeback bubble
// XLEN must match rv_wb_pkg::XLEN since buffered entries use the package type.
module wb_arbiter
  import rv_wb_pkg::wb_entry;
  import rv_wb_pkg::REG_AW;
#(
  parameter int XLEN         = rv_wb_pkg::XLEN,
  parameter int FIFO_DEPTH   = rv_wb_pkg::FIFO_DEPTH,
  parameter int STARVE_LIMIT = rv_wb_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_wb_valid,
  input  logic [REG_AW-1:0] pipe_wb_addr,
  input  logic [XLEN-1:0]   pipe_wb_data,
  input  logic              div_valid,
  input  logic [REG_AW-1:0] div_addr,
  input  logic [XLEN-1:0]   div_data,
  output logic              div_ready,
  output logic              write_enable,
  output logic [REG_AW-1:0] write_reg_addr,
  output logic [XLEN-1:0]   reg_write_data,
  output logic [31:0]       div_pending_mask,
  output logic              stall_req
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int WW = $clog2(STARVE_LIMIT+1);

  logic                              pipe_sel;
  logic                              push;
  logic                              pop;
  wb_entry                           head;
  logic [CW-1:0]                     count;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [FIFO_DEPTH-1:0]             entry_valid;
  logic [FIFO_DEPTH-1:0][REG_AW-1:0] entry_addr;
  logic [31:0]                       fifo_mask;
  logic [WW-1:0]                     wait_cnt_p1;
  logic [WW-1:0]                     wait_nx;
  logic                              ready_nx;
  logic                              from_div_p1;

  // A write to x0 is no write at all, from either source.
  assign pipe_sel = pipe_wb_valid && (pipe_wb_addr != '0);
  assign push     = div_valid && div_ready && (div_addr != '0);
  assign pop      = !pipe_sel && !fifo_empty;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{addr: div_addr, data: div_data}),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr)
  );

  always_comb begin
    int cnt_nx;
    cnt_nx   = int'(count) + (push ? 1 : 0) - (pop ? 1 : 0);
    ready_nx = (cnt_nx < FIFO_DEPTH);
    wait_nx  = '0;
    if (!pop && !fifo_empty)
      wait_nx = (wait_cnt_p1 == WW'(STARVE_LIMIT)) ? wait_cnt_p1 : wait_cnt_p1 + 1'b1;
  end

  always_comb begin
    fifo_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (entry_valid[i]) fifo_mask[entry_addr[i]] = 1'b1;
  end

  // A popped result stays marked pending during its write cycle, because the
  // register file only takes the value at the end of that cycle.
  assign div_pending_mask = fifo_mask | (from_div_p1 ? (32'd1 << write_reg_addr) : 32'd0);

  // Stage p0 -> p1: source selection into the registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable   <= 1'b0;
      write_reg_addr <= '0;
      reg_write_data <= '0;
      from_div_p1    <= 1'b0;
      wait_cnt_p1    <= '0;
      stall_req      <= 1'b0;
      div_ready      <= 1'b0;
    end else begin
      write_enable   <= pipe_sel || pop;
      write_reg_addr <= pipe_sel ? pipe_wb_addr : (pop ? head.addr : '0);
      reg_write_data <= pipe_sel ? pipe_wb_data : (pop ? head.data : '0);
      from_div_p1    <= pop;
      wait_cnt_p1    <= wait_nx;
      stall_req      <= (wait_nx == WW'(STARVE_LIMIT));
      div_ready      <= ready_nx;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_addr;
  logic [31:0] pipe_wb_data;
  logic        div_valid;
  logic [4:0]  div_addr;
  logic [31:0] div_data;
  logic        div_ready;
  logic        write_enable;
  logic [4:0]  write_reg_addr;
  logic [31:0] reg_write_data;
  logic [31:0] div_pending_mask;
  logic        stall_req;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .pipe_wb_valid   (pipe_wb_valid),
    .pipe_wb_addr    (pipe_wb_addr),
    .pipe_wb_data    (pipe_wb_data),
    .div_valid       (div_valid),
    .div_addr        (div_addr),
    .div_data        (div_data),
    .div_ready       (div_ready),
    .write_enable    (write_enable),
    .write_reg_addr  (write_reg_addr),
    .reg_write_data  (reg_write_data),
    .div_pending_mask(div_pending_mask),
    .stall_req       (stall_req)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"},   64'(write_enable),   64'(we));
    chk({tag, "_addr"}, 64'(write_reg_addr), 64'(a));
    chk({tag, "_data"}, 64'(reg_write_data), 64'(d));
  endtask

  initial begin
    reset = 1'b1;
    pipe_wb_valid = 1'b0; pipe_wb_addr = '0; pipe_wb_data = '0;
    div_valid = 1'b0; div_addr = '0; div_data = '0;
    #2 reset = 1'b0;

    // Reset state
    tick;
    tick;
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_mask",  64'(div_pending_mask), 64'h0);
    chk("rst_stall", 64'(stall_req), 64'h0);
    chk("rst_ready", 64'(div_ready), 64'h0);
    reset = 1'b1;
    tick;
    chk("ready_after_rst", 64'(div_ready), 64'h1);

    // Pipeline only: x5 = 0x1234 for exactly one cycle
    pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd5; pipe_wb_data = 32'h1234;
    tick;
    pipe_wb_valid = 1'b0;
    chk_wr("pipe", 1'b1, 5'd5, 32'h1234);
    tick;
    chk_wr("pipe_end", 1'b0, 5'd0, 32'h0);

    // Divider idle path: x7 = 0xDEAD, two-cycle latency
    div_valid = 1'b1; div_addr = 5'd7; div_data = 32'hDEAD;
    tick;
    div_valid = 1'b0;
    chk("div_mask_push", 64'(div_pending_mask), 64'h80);
    chk("div_we_early",  64'(write_enable), 64'h0);
    tick;
    chk_wr("div_write", 1'b1, 5'd7, 32'hDEAD);
    chk("div_mask_wr", 64'(div_pending_mask), 64'h80);
    tick;
    chk_wr("div_done", 1'b0, 5'd0, 32'h0);
    chk("div_mask_clr", 64'(div_pending_mask), 64'h0);

    // Contention and full: pipeline busy, x3 then x4 buffered, x9 held off
    pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd10; pipe_wb_data = 32'hA0;
    div_valid = 1'b1; div_addr = 5'd3; div_data = 32'h33;
    tick;
    chk("full1_ready", 64'(div_ready), 64'h1);
    chk_wr("full1_pipe", 1'b1, 5'd10, 32'hA0);
    div_addr = 5'd4; div_data = 32'h44; pipe_wb_data = 32'hA1;
    tick;
    chk("full2_ready", 64'(div_ready), 64'h0);
    chk("full2_mask",  64'(div_pending_mask), 64'h18);
    div_addr = 5'd9; div_data = 32'h99; pipe_wb_data = 32'hA2;
    tick;
    chk("held_ready", 64'(div_ready), 64'h0);
    chk("held_mask",  64'(div_pending_mask), 64'h18);
    chk_wr("held_pipe", 1'b1, 5'd10, 32'hA2);
    div_valid = 1'b0; pipe_wb_valid = 1'b0;
    tick;
    chk_wr("drain_x3", 1'b1, 5'd3, 32'h33);
    tick;
    chk_wr("drain_x4", 1'b1, 5'd4, 32'h44);
    chk("drain_mask", 64'(div_pending_mask), 64'h10);
    tick;
    chk_wr("drain_end", 1'b0, 5'd0, 32'h0);
    chk("drain_mask0", 64'(div_pending_mask), 64'h0);
    chk("drain_ready", 64'(div_ready), 64'h1);

    // Starvation: x6 waits behind continuous pipeline writes
    pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd12; pipe_wb_data = 32'hC0;
    div_valid = 1'b1; div_addr = 5'd6; div_data = 32'h66;
    tick;
    div_valid = 1'b0;
    chk("starve_mask", 64'(div_pending_mask), 64'h40);
    tick;
    tick;
    tick;
    chk("starve_3", 64'(stall_req), 64'h0);
    tick;
    chk("starve_4", 64'(stall_req), 64'h1);
    chk_wr("starve_pipe", 1'b1, 5'd12, 32'hC0);
    pipe_wb_valid = 1'b0;
    tick;
    chk_wr("starve_wr", 1'b1, 5'd6, 32'h66);
    chk("starve_clr", 64'(stall_req), 64'h0);
    tick;
    chk_wr("starve_end", 1'b0, 5'd0, 32'h0);

    // x0 handling
    div_valid = 1'b1; div_addr = 5'd0; div_data = 32'h5555;
    tick;
    div_valid = 1'b0;
    chk("x0_ready", 64'(div_ready), 64'h1);
    chk("x0_mask",  64'(div_pending_mask), 64'h0);
    tick;
    chk("x0_nowrite", 64'(write_enable), 64'h0);
    pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd11; pipe_wb_data = 32'hB1;
    div_valid = 1'b1; div_addr = 5'd8; div_data = 32'h88;
    tick;
    div_valid = 1'b0;
    chk_wr("x0_pipe11", 1'b1, 5'd11, 32'hB1);
    chk("x0_mask8", 64'(div_pending_mask), 64'h100);
    pipe_wb_addr = 5'd0; pipe_wb_data = 32'hFFFF;
    tick;
    chk_wr("x0_drain", 1'b1, 5'd8, 32'h88);
    pipe_wb_valid = 1'b0;
    tick;
    chk_wr("x0_end", 1'b0, 5'd0, 32'h0);

    // Reset mid-operation with two buffered entries
    pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd13; pipe_wb_data = 32'hD0;
    div_valid = 1'b1; div_addr = 5'd1; div_data = 32'h11;
    tick;
    div_addr = 5'd2; div_data = 32'h22;
    tick;
    div_valid = 1'b0;
    chk("mid_mask", 64'(div_pending_mask), 64'h6);
    chk("mid_ready", 64'(div_ready), 64'h0);
    #3 reset = 1'b0;
    #1;
    chk_wr("mid_rst", 1'b0, 5'd0, 32'h0);
    chk("mid_rst_mask",  64'(div_pending_mask), 64'h0);
    chk("mid_rst_ready", 64'(div_ready), 64'h0);
    chk("mid_rst_stall", 64'(stall_req), 64'h0);
    pipe_wb_valid = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_rst_we",   64'(write_enable), 64'h0);
      chk("post_rst_mask", 64'(div_pending_mask), 64'h0);
    end
    chk("post_rst_ready", 64'(div_ready), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
